// File: rtl/incdec_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_exec_pkg
//  Description : Shared definitions for the INR/DCR execution sequencer:
//                8085 register codes, flag bit positions, sequencer states.
//  Revision    : 1.0  initial release
// ============================================================================
package incdec_exec_pkg;

    // 8085 DDD register codes; code 3'b110 selects memory at HL
    localparam logic [2:0] REG_B = 3'b000;
    localparam logic [2:0] REG_C = 3'b001;
    localparam logic [2:0] REG_D = 3'b010;
    localparam logic [2:0] REG_E = 3'b011;
    localparam logic [2:0] REG_H = 3'b100;
    localparam logic [2:0] REG_L = 3'b101;
    localparam logic [2:0] REG_M = 3'b110;
    localparam logic [2:0] REG_A = 3'b111;

    // Flag register bit positions
    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_AC = 4;
    localparam int FLAG_P  = 2;
    localparam int FLAG_CY = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MRD  = 3'd1,
        ST_EXEC = 3'd2,
        ST_MWR  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    function automatic logic is_mem(input logic [2:0] code);
        return code == REG_M;
    endfunction

endpackage
`default_nettype wire

// File: rtl/incdec_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_exec_if
//  Description : Bundle of the sequencer's control, register-file, memory and
//                flag-register signals.
//                slave  : the sequencer side (drives the o* signals)
//                master : the control unit / regfile / bus-unit side
//  Revision    : 1.0  initial release
// ============================================================================
interface incdec_exec_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int FLAGSIZE = 8
);
    // control unit
    logic                iStart;
    logic                iDec;
    logic [2:0]          iReg;
    logic [ADDRSIZE-1:0] iHL;
    logic [FLAGSIZE-1:0] iFlag;
    // register file
    logic [2:0]          oRRdAddr;
    logic [DATASIZE-1:0] iRRdData;
    logic                oRWrEn;
    logic [2:0]          oRWrAddr;
    logic [DATASIZE-1:0] oRWrData;
    // memory / bus interface unit
    logic                oMemRd;
    logic                oMemWr;
    logic [ADDRSIZE-1:0] oMemAddr;
    logic [DATASIZE-1:0] oMemWData;
    logic [DATASIZE-1:0] iMemRData;
    logic                iMemRdy;
    // flags and status
    logic                oFlagWr;
    logic [FLAGSIZE-1:0] oFlag;
    logic                oBusy;
    logic                oDone;

    modport slave (
        input  iStart, iDec, iReg, iHL, iFlag, iRRdData, iMemRData, iMemRdy,
        output oRRdAddr, oRWrEn, oRWrAddr, oRWrData, oMemRd, oMemWr,
               oMemAddr, oMemWData, oFlagWr, oFlag, oBusy, oDone
    );

    modport master (
        output iStart, iDec, iReg, iHL, iFlag, iRRdData, iMemRData, iMemRdy,
        input  oRRdAddr, oRWrEn, oRWrAddr, oRWrData, oMemRd, oMemWr,
               oMemAddr, oMemWData, oFlagWr, oFlag, oBusy, oDone
    );
endinterface
`default_nettype wire

// File: rtl/incdec_exec_incdec.sv
`default_nettype none
// ============================================================================
//  Module      : incdec
//  Description : Combinational increment/decrement unit with 8085 status.
//                iData  operand, iDec 0=increment 1=decrement
//                oRes   result modulo 2^DATASIZE
//                oS/oZ/oAC/oP  sign, zero, auxiliary carry, even parity
//  Revision    : 1.0  initial release
// ============================================================================
module incdec #(
    parameter int DATASIZE = 8
) (
    input  wire logic [DATASIZE-1:0] iData,
    input  wire logic                iDec,
    output logic      [DATASIZE-1:0] oRes,
    output logic                     oS,
    output logic                     oZ,
    output logic                     oAC,
    output logic                     oP
);
    always_comb begin
        oRes = iDec ? (iData - DATASIZE'(1)) : (iData + DATASIZE'(1));
        oS   = oRes[DATASIZE-1];
        oZ   = (oRes == '0);
        oP   = ~^oRes;
        // Carry out of bit 3 on increment, borrow into bit 4 on decrement
        oAC  = iDec ? (iData[3:0] == 4'h0) : (iData[3:0] == 4'hF);
    end
endmodule
`default_nettype wire

// File: rtl/incdec_exec.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_exec
//  Description : Execution sequencer for 8085 INR r / DCR r / INR M / DCR M.
//                Fetches the operand (register file or memory at HL), runs it
//                through the incdec unit, writes back result and merged flags.
//  Ports       : iClk    clock, rising edge
//                iRst_n  asynchronous reset, active low
//                bus     incdec_exec_if.slave: start/opcode/HL/flags in,
//                        regfile read/write, memory read/write handshake,
//                        flag write, busy and done status
//  Revision    : 1.0  initial release
// ============================================================================
module incdec_exec
    import incdec_exec_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int FLAGSIZE = 8
) (
    input  wire logic     iClk,
    input  wire logic     iRst_n,
    incdec_exec_if.slave  bus
);
    state_t              state_q, state_d;
    logic                dec_q, dec_d;
    logic [2:0]          code_q, code_d;
    logic [ADDRSIZE-1:0] hl_q, hl_d;
    logic [FLAGSIZE-1:0] flag_q, flag_d;     // flags as sampled at start
    logic [DATASIZE-1:0] opnd_q, opnd_d;
    logic [DATASIZE-1:0] res_q, res_d;
    logic [FLAGSIZE-1:0] nflag_q, nflag_d;   // merged flags for write-back

    logic [DATASIZE-1:0] w_res;
    logic                w_s, w_z, w_ac, w_p;
    logic [FLAGSIZE-1:0] w_flag;

    incdec #(.DATASIZE(DATASIZE)) u_incdec (
        .iData (opnd_q),
        .iDec  (dec_q),
        .oRes  (w_res),
        .oS    (w_s),
        .oZ    (w_z),
        .oAC   (w_ac),
        .oP    (w_p)
    );

    // Carry and the unused bits pass through untouched: INR/DCR never alter CY
    always_comb begin
        w_flag          = flag_q;
        w_flag[FLAG_S]  = w_s;
        w_flag[FLAG_Z]  = w_z;
        w_flag[FLAG_AC] = w_ac;
        w_flag[FLAG_P]  = w_p;
    end

    // Register read address follows the opcode directly so the operand is
    // available in the same cycle the start is accepted.
    assign bus.oRRdAddr = bus.iReg;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        code_d  = code_q;
        hl_d    = hl_q;
        flag_d  = flag_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        nflag_d = nflag_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    dec_d  = bus.iDec;
                    code_d = bus.iReg;
                    hl_d   = bus.iHL;
                    flag_d = bus.iFlag;
                    if (is_mem(bus.iReg)) begin
                        state_d = ST_MRD;
                    end else begin
                        opnd_d  = bus.iRRdData;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_MRD: begin
                if (bus.iMemRdy) begin
                    opnd_d  = bus.iMemRData;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = w_res;
                nflag_d = w_flag;
                state_d = is_mem(code_q) ? ST_MWR : ST_WB;
            end
            ST_MWR: begin
                if (bus.iMemRdy) state_d = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: everything decoded from the registered state, so an
    // asynchronous reset drops every strobe at once.
    always_comb begin
        bus.oRWrEn    = 1'b0;
        bus.oRWrAddr  = '0;
        bus.oRWrData  = '0;
        bus.oMemRd    = 1'b0;
        bus.oMemWr    = 1'b0;
        bus.oMemAddr  = '0;
        bus.oMemWData = '0;
        bus.oFlagWr   = 1'b0;
        bus.oFlag     = '0;
        bus.oDone     = 1'b0;
        bus.oBusy     = (state_q != ST_IDLE);
        case (state_q)
            ST_MRD: begin
                bus.oMemRd   = 1'b1;
                bus.oMemAddr = hl_q;
            end
            ST_MWR: begin
                bus.oMemWr    = 1'b1;
                bus.oMemAddr  = hl_q;
                bus.oMemWData = res_q;
            end
            ST_WB: begin
                bus.oFlagWr = 1'b1;
                bus.oFlag   = nflag_q;
                bus.oDone   = 1'b1;
                if (!is_mem(code_q)) begin
                    bus.oRWrEn   = 1'b1;
                    bus.oRWrAddr = code_q;
                    bus.oRWrData = res_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            dec_q   <= 1'b0;
            code_q  <= '0;
            hl_q    <= '0;
            flag_q  <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            nflag_q <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            code_q  <= code_d;
            hl_q    <= hl_d;
            flag_q  <= flag_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            nflag_q <= nflag_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_incdec_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_incdec_exec
//  Description : Self-checking bench for incdec_exec. Register file and memory
//                are modelled here; a reference model computes INR/DCR results
//                and flags arithmetically.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_incdec_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    incdec_exec_if #(.DATASIZE(8), .ADDRSIZE(16), .FLAGSIZE(8)) bus ();

    incdec_exec #(.DATASIZE(8), .ADDRSIZE(16), .FLAGSIZE(8)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] regs [8];
    logic [7:0] mem [int];
    assign bus.iRRdData = regs[bus.oRRdAddr];

    int         done_cnt = 0, flagwr_cnt = 0, rwr_cnt = 0, mem_wr_cnt = 0;
    logic [7:0] last_flag = 8'h00;
    logic [2:0] last_waddr = 3'd0;
    int         mem_wr_addr = 0;
    logic [7:0] mem_wr_data = 8'h00;
    int         rd_wait = 0, wr_wait = 0, wait_cnt = 0;
    bit         noise_en = 1'b0;

    // Monitor + memory responder, both on the falling edge
    always @(negedge clk) begin
        if (bus.oDone)   done_cnt++;
        if (bus.oFlagWr) begin flagwr_cnt++; last_flag = bus.oFlag; end
        if (bus.oRWrEn)  begin rwr_cnt++; last_waddr = bus.oRWrAddr; regs[bus.oRWrAddr] = bus.oRWrData; end
        if (bus.oMemRd || bus.oMemWr) begin
            if (wait_cnt < (bus.oMemRd ? rd_wait : wr_wait)) begin
                wait_cnt++;
                bus.iMemRdy = 1'b0;
            end else begin
                bus.iMemRdy = 1'b1;
                if (bus.oMemRd) begin
                    bus.iMemRData = mem.exists(int'(bus.oMemAddr)) ? mem[int'(bus.oMemAddr)] : 8'h00;
                end else begin
                    mem_wr_cnt++;
                    mem_wr_addr = int'(bus.oMemAddr);
                    mem_wr_data = bus.oMemWData;
                    mem[int'(bus.oMemAddr)] = bus.oMemWData;
                end
            end
        end else begin
            wait_cnt      = 0;
            bus.iMemRdy   = noise_en ? 1'($urandom) : 1'b0;
            bus.iMemRData = 8'($urandom);
        end
    end

    // Reference model: plain modular arithmetic and bit counting
    function automatic void model(input bit dec, input int v, input int fin,
                                  output int res, output int fl);
        int ones;
        bit ac;
        res  = dec ? (v + 255) % 256 : (v + 1) % 256;
        ac   = dec ? ((v % 16) - 1 < 0) : ((v % 16) + 1 >= 16);
        ones = 0;
        for (int b = 0; b < 8; b++) ones += (res >> b) & 1;
        fl = (res >= 128 ? 128 : 0) + (res == 0 ? 64 : 0) + (ac ? 16 : 0)
           + (ones % 2 == 0 ? 4 : 0) + (fin & 'h2B);
    endfunction

    // Issue one operation and wait for its completion pulse
    task automatic run_op(input bit dec, input logic [2:0] code, input logic [15:0] hl,
                          input logic [7:0] fl, input bit pulse_busy,
                          output int lat, output bit timeout);
        @(negedge clk);
        bus.iStart = 1'b1; bus.iDec = dec; bus.iReg = code; bus.iHL = hl; bus.iFlag = fl;
        lat = 1; timeout = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            lat++;
            bus.iDec  = 1'($urandom);
            bus.iReg  = 3'($urandom);
            bus.iHL   = 16'($urandom);
            bus.iFlag = 8'($urandom);
            if (bus.oDone) begin
                bus.iStart = 1'b0;
                timeout = 1'b0;
                break;
            end
            bus.iStart = pulse_busy ? 1'($urandom) : 1'b0;
        end
        bus.iStart = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.oBusy, bus.oDone, bus.oRWrEn, bus.oMemRd, bus.oMemWr, bus.oFlagWr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {bus.oBusy, bus.oDone, bus.oRWrEn, bus.oMemRd, bus.oMemWr, bus.oFlagWr});
        end
        checks++;
        if ({bus.oMemAddr, bus.oMemWData, bus.oRWrData, bus.oRWrAddr, bus.oFlag} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wd=%h rd=%h ra=%h fl=%h exp all 0",
                     bus.oMemAddr, bus.oMemWData, bus.oRWrData, bus.oRWrAddr, bus.oFlag);
        end
    endtask

    // Register-operand op with full result/flag/latency/strobe checking
    task automatic test_reg_op(input string name, input bit dec, input logic [2:0] code,
                               input logic [7:0] val, input logic [7:0] fin, input bit pulse);
        int lat, er, ef, r0, m0, d0;
        bit to;
        regs[code] = val;
        model(dec, int'(val), int'(fin), er, ef);
        r0 = rwr_cnt; m0 = mem_wr_cnt; d0 = done_cnt;
        run_op(dec, code, 16'($urandom), fin, pulse, lat, to);
        checks++;
        if (to || lat != 3) begin errors++; $display("FAIL %s latency got=%0d timeout=%0d exp=3", name, lat, to); end
        checks++;
        if (regs[code] !== 8'(er) || last_waddr !== code) begin
            errors++; $display("FAIL %s result got=%h@%0d exp=%h@%0d", name, regs[code], last_waddr, 8'(er), code);
        end
        checks++;
        if (last_flag !== 8'(ef)) begin errors++; $display("FAIL %s flags got=%h exp=%h", name, last_flag, 8'(ef)); end
        checks++;
        if (rwr_cnt - r0 != 1 || mem_wr_cnt != m0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL %s strobes got rwr=%0d mwr=%0d done=%0d exp 1/0/1",
                               name, rwr_cnt - r0, mem_wr_cnt - m0, done_cnt - d0);
        end
    endtask

    // Memory-operand op
    task automatic test_mem_op(input string name, input bit dec, input logic [15:0] hl,
                               input logic [7:0] val, input logic [7:0] fin,
                               input int rw, input int ww, input bit pulse);
        int lat, er, ef, r0, m0, d0;
        bit to;
        mem[int'(hl)] = val;
        rd_wait = rw; wr_wait = ww;
        model(dec, int'(val), int'(fin), er, ef);
        r0 = rwr_cnt; m0 = mem_wr_cnt; d0 = done_cnt;
        run_op(dec, incdec_exec_pkg::REG_M, hl, fin, pulse, lat, to);
        checks++;
        if (to || lat != 5 + rw + ww) begin
            errors++; $display("FAIL %s latency got=%0d timeout=%0d exp=%0d", name, lat, to, 5 + rw + ww);
        end
        checks++;
        if (mem_wr_cnt - m0 != 1 || mem_wr_addr != int'(hl) || mem_wr_data !== 8'(er)) begin
            errors++; $display("FAIL %s memwrite got n=%0d %h@%h exp n=1 %h@%h",
                               name, mem_wr_cnt - m0, mem_wr_data, mem_wr_addr, 8'(er), hl);
        end
        checks++;
        if (last_flag !== 8'(ef)) begin errors++; $display("FAIL %s flags got=%h exp=%h", name, last_flag, 8'(ef)); end
        checks++;
        if (rwr_cnt != r0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL %s strobes got rwr=%0d done=%0d exp 0/1", name, rwr_cnt - r0, done_cnt - d0);
        end
        rd_wait = 0; wr_wait = 0;
    endtask

    task automatic test_busy_start();
        test_mem_op("busy_start", 1'b0, 16'h1234, 8'h3C, 8'hA5, 2, 1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL busy_start_noqueue got busy=%b exp=0", bus.oBusy); end
    endtask

    task automatic test_reset_mwr();
        int d0, f0, m0;
        bit seen;
        mem[int'(16'h4000)] = 8'h10;
        rd_wait = 0; wr_wait = 1000;
        d0 = done_cnt; f0 = flagwr_cnt; m0 = mem_wr_cnt;
        @(negedge clk);
        bus.iStart = 1'b1; bus.iDec = 1'b0; bus.iReg = incdec_exec_pkg::REG_M;
        bus.iHL = 16'h4000; bus.iFlag = 8'h00;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.iStart = 1'b0;
            if (bus.oMemWr) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mwr_reach got memwr=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.oMemWr, bus.oBusy, bus.oFlagWr, bus.oDone} !== 4'b0) begin
            errors++; $display("FAIL rst_mwr_drop got wr/busy/fwr/done=%b exp=0000",
                               {bus.oMemWr, bus.oBusy, bus.oFlagWr, bus.oDone});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_wait = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != d0 || flagwr_cnt != f0 || mem_wr_cnt != m0 || bus.oBusy !== 1'b0) begin
            errors++; $display("FAIL rst_mwr_abort got done=%0d fwr=%0d mwr=%0d busy=%b exp 0/0/0/0",
                               done_cnt - d0, flagwr_cnt - f0, mem_wr_cnt - m0, bus.oBusy);
        end
        test_reg_op("rst_then_inr_e", 1'b0, incdec_exec_pkg::REG_E, 8'h4F, 8'h2A, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] code;
        for (int i = 0; i < 30; i++) begin
            code = 3'($urandom);
            if (code == incdec_exec_pkg::REG_M)
                test_mem_op("rand_mem", 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                            $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
            else
                test_reg_op("rand_reg", 1'($urandom), code, 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        bus.iStart = 1'b0; bus.iDec = 1'b0; bus.iReg = 3'd0; bus.iHL = 16'h0; bus.iFlag = 8'h0;
        bus.iMemRdy = 1'b0; bus.iMemRData = 8'h0;
        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reg_op("inr_b", 1'b0, incdec_exec_pkg::REG_B, 8'h7F, 8'h01, 1'b0);
        test_reg_op("dcr_a", 1'b1, incdec_exec_pkg::REG_A, 8'h01, 8'h00, 1'b0);
        test_mem_op("inr_m", 1'b0, 16'h2000, 8'hFF, 8'h00, 1, 1, 1'b0);
        test_reg_op("dcr_c", 1'b1, incdec_exec_pkg::REG_C, 8'h00, 8'h01, 1'b0);
        noise_en = 1'b1;
        test_busy_start();
        test_reset_mwr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
